// File: rtl/axi_pkg.sv
// Shared AXI interconnect definitions: AR arbiter states, slave address map
// and the width of the master-index tag prepended to slave-side IDs.
package axi_pkg;

   // Width of the master-index field prepended to slave-side IDs
   localparam int unsigned AXI_MIDX_BITS = 4;

   // Address width and number of entries in the slave map
   localparam int unsigned MAP_BITS = 32;
   localparam int unsigned MAP_LEN  = 3;

   // AR arbiter FSM states
   typedef enum logic [1:0] {
      AR_IDLE = 2'd0,
      AR_ADDR = 2'd1,
      AR_DATA = 2'd2
   } ar_state_e;

   // Inclusive slave address windows; the first matching entry wins
   localparam logic [MAP_BITS-1:0] SLV_BASE [MAP_LEN] = '{
      32'h1000_0000,
      32'h2000_0000,
      32'h3000_0000
   };

   localparam logic [MAP_BITS-1:0] SLV_LAST [MAP_LEN] = '{
      32'h1FFF_FFFF,
      32'h2FFF_FFFF,
      32'h3FFF_FFFF
   };

endpackage

// File: rtl/axi_ar_decoder.sv
// Combinational address decoder against the shared slave map. It returns the
// first matching slave index and a hit flag. On a miss, sel is 0.
// The AW arbiter uses this block too.
module axi_ar_decoder
   import axi_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = MAP_LEN,
   parameter int unsigned ADDR_BITS  = 32,
   parameter int unsigned SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic [ADDR_BITS-1:0] addr,
   output logic [SEL_BITS-1:0]  sel,
   output logic                 hit
);

   localparam int unsigned CMP_BITS = (ADDR_BITS > MAP_BITS) ? ADDR_BITS : MAP_BITS;

   // Priority search: the lowest-numbered matching window wins
   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (!hit &&
             (CMP_BITS'(addr) >= CMP_BITS'(SLV_BASE[i])) &&
             (CMP_BITS'(addr) <= CMP_BITS'(SLV_LAST[i]))) begin
            hit = 1'b1;
            sel = SEL_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin AXI read-address arbiter. It grants one master, decodes the
// granted address and routes AR valid/ready to one slave. The grant is held
// until the RLAST handshake of the burst.
// Optional: define AXI_AR_DECERR_EN to accept decode misses locally and flag
// them for a default-slave responder (decerr_o / decerr_id_o).
module axi_ar_rr_arbiter
   import axi_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned NUM_SLAVES  = 3,
   parameter int unsigned ID_BITS     = 4,
   parameter int unsigned ADDR_BITS   = 32,
   parameter int unsigned LEN_BITS    = 4,
   parameter int unsigned SIZE_BITS   = 3
) (
   input  logic                                   ACLK,
   input  logic                                   ARESETn,
   input  logic [NUM_MASTERS-1:0][ID_BITS-1:0]    ARID_M,
   input  logic [NUM_MASTERS-1:0][ADDR_BITS-1:0]  ARADDR_M,
   input  logic [NUM_MASTERS-1:0][LEN_BITS-1:0]   ARLEN_M,
   input  logic [NUM_MASTERS-1:0][SIZE_BITS-1:0]  ARSIZE_M,
   input  logic [NUM_MASTERS-1:0][1:0]            ARBURST_M,
   input  logic [NUM_MASTERS-1:0]                 ARVALID_M,
   output logic [NUM_MASTERS-1:0]                 ARREADY_M,
   input  logic [NUM_MASTERS-1:0]                 RVALID_M,
   input  logic [NUM_MASTERS-1:0]                 RREADY_M,
   input  logic [NUM_MASTERS-1:0]                 RLAST_M,
   output logic [ID_BITS+AXI_MIDX_BITS-1:0]       ARID_S,
   output logic [ADDR_BITS-1:0]                   ARADDR_S,
   output logic [LEN_BITS-1:0]                    ARLEN_S,
   output logic [SIZE_BITS-1:0]                   ARSIZE_S,
   output logic [1:0]                             ARBURST_S,
   output logic [NUM_SLAVES-1:0]                  ARVALID_S,
   input  logic [NUM_SLAVES-1:0]                  ARREADY_S,
   output logic [NUM_MASTERS-1:0]                 grant_o,
   output logic                                   busy_o
`ifdef AXI_AR_DECERR_EN
   ,
   output logic                                   decerr_o,
   output logic [ID_BITS+AXI_MIDX_BITS-1:0]       decerr_id_o
`endif
);

   localparam int unsigned IDX_W    = $clog2(NUM_MASTERS);
   localparam int unsigned TID_W    = ID_BITS + AXI_MIDX_BITS;
   localparam int unsigned SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   ar_state_e              state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       gnt_q, gnt_d;
   logic [TID_W-1:0]       cap_id_q, cap_id_d;
   logic [ADDR_BITS-1:0]   cap_addr_q, cap_addr_d;
   logic [LEN_BITS-1:0]    cap_len_q, cap_len_d;
   logic [SIZE_BITS-1:0]   cap_size_q, cap_size_d;
   logic [1:0]             cap_burst_q, cap_burst_d;
`ifdef AXI_AR_DECERR_EN
   logic                   decerr_q, decerr_d;
   logic [TID_W-1:0]       decerr_id_q, decerr_id_d;
`endif

   logic [IDX_W-1:0]       win_idx;
   logic                   win_found;
   int unsigned            cand;
   logic [SEL_BITS-1:0]    dec_sel, sel;
   logic                   dec_hit;
   logic                   ar_hs;

   // Decode the address of the currently granted master
   axi_ar_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_BITS  (ADDR_BITS),
      .SEL_BITS   (SEL_BITS)
   ) u_dec (
      .addr (ARADDR_M[gnt_q]),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

`ifdef AXI_AR_DECERR_EN
   assign sel = dec_sel;
`else
   // A miss falls through to slave 0
   assign sel = dec_hit ? dec_sel : '0;
`endif

   // Round-robin search: find the first requester at or above rr_ptr, wrapping to 0
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         if (!win_found && ARVALID_M[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // State, pointer, grant and capture registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= AR_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         cap_id_q    <= '0;
         cap_addr_q  <= '0;
         cap_len_q   <= '0;
         cap_size_q  <= '0;
         cap_burst_q <= '0;
`ifdef AXI_AR_DECERR_EN
         decerr_q    <= 1'b0;
         decerr_id_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         cap_id_q    <= cap_id_d;
         cap_addr_q  <= cap_addr_d;
         cap_len_q   <= cap_len_d;
         cap_size_q  <= cap_size_d;
         cap_burst_q <= cap_burst_d;
`ifdef AXI_AR_DECERR_EN
         decerr_q    <= decerr_d;
         decerr_id_q <= decerr_id_d;
`endif
      end
   end

   // Next-state logic and AR routing. The ADDR path is combinational from
   // master to slave and back.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      cap_id_d    = cap_id_q;
      cap_addr_d  = cap_addr_q;
      cap_len_d   = cap_len_q;
      cap_size_d  = cap_size_q;
      cap_burst_d = cap_burst_q;
`ifdef AXI_AR_DECERR_EN
      decerr_d    = 1'b0;
      decerr_id_d = decerr_id_q;
`endif
      ARVALID_S   = '0;
      ARREADY_M   = '0;
      ARID_S      = cap_id_q;
      ARADDR_S    = cap_addr_q;
      ARLEN_S     = cap_len_q;
      ARSIZE_S    = cap_size_q;
      ARBURST_S   = cap_burst_q;
      grant_o     = '0;
      busy_o      = 1'b0;
      ar_hs       = 1'b0;

      case (state_q)
         AR_IDLE: begin
            if (win_found) begin
               gnt_d   = win_idx;
               state_d = AR_ADDR;
            end
         end

         AR_ADDR: begin
            busy_o         = 1'b1;
            grant_o[gnt_q] = 1'b1;
            ARID_S         = {AXI_MIDX_BITS'(gnt_q), ARID_M[gnt_q]};
            ARADDR_S       = ARADDR_M[gnt_q];
            ARLEN_S        = ARLEN_M[gnt_q];
            ARSIZE_S       = ARSIZE_M[gnt_q];
            ARBURST_S      = ARBURST_M[gnt_q];
`ifdef AXI_AR_DECERR_EN
            if (dec_hit) begin
               ARVALID_S[sel]   = ARVALID_M[gnt_q];
               ARREADY_M[gnt_q] = ARREADY_S[sel];
            end else begin
               ARREADY_M[gnt_q] = ARVALID_M[gnt_q];
            end
`else
            ARVALID_S[sel]   = ARVALID_M[gnt_q];
            ARREADY_M[gnt_q] = ARREADY_S[sel];
`endif
            ar_hs = ARVALID_M[gnt_q] & ARREADY_M[gnt_q];
            if (ar_hs) begin
               cap_id_d    = ARID_S;
               cap_addr_d  = ARADDR_M[gnt_q];
               cap_len_d   = ARLEN_M[gnt_q];
               cap_size_d  = ARSIZE_M[gnt_q];
               cap_burst_d = ARBURST_M[gnt_q];
               state_d     = AR_DATA;
`ifdef AXI_AR_DECERR_EN
               if (!dec_hit) begin
                  decerr_d    = 1'b1;
                  decerr_id_d = ARID_S;
               end
`endif
            end
         end

         AR_DATA: begin
            busy_o         = 1'b1;
            grant_o[gnt_q] = 1'b1;
            if (RVALID_M[gnt_q] & RREADY_M[gnt_q] & RLAST_M[gnt_q]) begin
               state_d  = AR_IDLE;
               rr_ptr_d = (gnt_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_q + IDX_W'(1);
            end
         end

         default: state_d = AR_IDLE;
      endcase
   end

`ifdef AXI_AR_DECERR_EN
   assign decerr_o    = decerr_q;
   assign decerr_id_o = decerr_id_q;
`endif

endmodule
